// File: rtl/audioport_pkg.sv
// Shared types and limits for the audio port sample scheduler.
package audioport_pkg;

   typedef enum logic {
      STOPPED = 1'b0,
      COUNT   = 1'b1
   } sched_state_t;

   localparam int SCHED_MIN_DIV = 2;

endpackage

// File: rtl/sched_divider.sv
// Down-counter that sets the sample period: reloads on load or on reaching zero while enabled.
module sched_divider #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] load_val,
   output logic             zero
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load || (en && cnt == '0)) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sample_scheduler.sv
// Stereo sample scheduler: paces FIFO pops and dsp ticks from clk_div_in, flags underruns.
// Define SAMPLE_SCHEDULER_IRQ_EN to build the underrun interrupt flop; otherwise irq_out is 0.
module sample_scheduler
   import audioport_pkg::*;
#(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_in,
   input  logic             stop_in,
   input  logic             clr_in,
   input  logic             irqack_in,
   input  logic [DIV_W-1:0] clk_div_in,
   input  logic             l_empty_in,
   input  logic             r_empty_in,
   output logic             l_pop_out,
   output logic             r_pop_out,
   output logic             tick_out,
   output logic             zero_out,
   output logic             play_out,
   output logic             nodata_out,
   output logic             irq_out
);

   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(SCHED_MIN_DIV);

   sched_state_t     state;
   logic             tick_pending;
   logic [DIV_W-1:0] eff_div;
   logic             start_go;
   logic             div_zero;
   logic             zero_hit;
   logic             underrun;

   assign eff_div  = (clk_div_in < MIN_DIV) ? MIN_DIV : clk_div_in;
   assign start_go = (state == STOPPED) && start_in && !stop_in;
   assign zero_hit = (state == COUNT) && div_zero;
   assign underrun = zero_hit && (l_empty_in || r_empty_in);

   sched_divider #(.DIV_W(DIV_W)) u_divider (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_go),
      .en       (state == COUNT),
      .load_val (eff_div - 1'b1),
      .zero     (div_zero)
   );

   // Both channels pop together or not at all, so the stereo pair never skews.
   assign l_pop_out = zero_hit && !l_empty_in && !r_empty_in;
   assign r_pop_out = l_pop_out;
   assign tick_out  = tick_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= STOPPED;
         play_out     <= 1'b0;
         tick_pending <= 1'b0;
         zero_out     <= 1'b0;
         nodata_out   <= 1'b0;
      end else begin
         unique case (state)
            STOPPED: if (start_go) begin
               state    <= COUNT;
               play_out <= 1'b1;
            end
            COUNT: if (stop_in) begin
               state    <= STOPPED;
               play_out <= 1'b0;
            end
            default: begin
               state    <= STOPPED;
               play_out <= 1'b0;
            end
         endcase
         tick_pending <= zero_hit;
         zero_out     <= underrun;
         if (underrun) begin
            nodata_out <= 1'b1;
         end else if (clr_in && state == STOPPED) begin
            nodata_out <= 1'b0;
         end
      end
   end

`ifdef SAMPLE_SCHEDULER_IRQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_out <= 1'b0;
      end else if (underrun) begin
         irq_out <= 1'b1;
      end else if (irqack_in || (clr_in && state == STOPPED)) begin
         irq_out <= 1'b0;
      end
   end
`else
   logic unused_irqack;
   assign unused_irqack = irqack_in;
   assign irq_out       = 1'b0;
`endif

endmodule

// File: tb/tb_sample_scheduler.sv
// Self-checking bench for sample_scheduler: event-time reference model plus scripted corner cases.
module tb_sample_scheduler;

   localparam int DIV_W = 32;
`ifdef SAMPLE_SCHEDULER_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_in = 1'b0, stop_in = 1'b0, clr_in = 1'b0, irqack_in = 1'b0;
   logic [DIV_W-1:0] clk_div_in = 4;
   logic l_empty_in = 1'b0, r_empty_in = 1'b0;
   logic l_pop_out, r_pop_out, tick_out, zero_out, play_out, nodata_out, irq_out;

   sample_scheduler #(.DIV_W(DIV_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_in   (start_in),
      .stop_in    (stop_in),
      .clr_in     (clr_in),
      .irqack_in  (irqack_in),
      .clk_div_in (clk_div_in),
      .l_empty_in (l_empty_in),
      .r_empty_in (r_empty_in),
      .l_pop_out  (l_pop_out),
      .r_pop_out  (r_pop_out),
      .tick_out   (tick_out),
      .zero_out   (zero_out),
      .play_out   (play_out),
      .nodata_out (nodata_out),
      .irq_out    (irq_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int base = 1000000;

   always @(posedge clk) cyc <= cyc + 1;

   // Per-scenario log of outputs, indexed by cycle relative to the scenario's cycle 0.
   logic [1:0] pop_log [64];
   logic tick_log [64], zero_log [64], play_log [64], nodata_log [64], irq_log [64];

   // Reference model: a pop/underrun decision falls due at m_next; the next one is eff_div later.
   bit m_run = 0, m_tick = 0, m_zero = 0, m_nodata = 0, m_irq = 0;
   int m_next = 0;
   bit m_hit, m_und;
   int m_eff, rel;
   logic [6:0] m_act, m_exp;

   always @(negedge clk) begin
      rel = cyc - base;
      if (rel >= 0 && rel < 64) begin
         pop_log[rel]    = {l_pop_out, r_pop_out};
         tick_log[rel]   = tick_out;
         zero_log[rel]   = zero_out;
         play_log[rel]   = play_out;
         nodata_log[rel] = nodata_out;
         irq_log[rel]    = irq_out;
      end
      m_act = {l_pop_out, r_pop_out, tick_out, zero_out, play_out, nodata_out, irq_out};
      if (!rst_n) begin
         m_run = 0; m_tick = 0; m_zero = 0; m_nodata = 0; m_irq = 0;
         m_exp = '0;
      end else begin
         m_hit = m_run && (cyc == m_next);
         m_und = m_hit && (l_empty_in || r_empty_in);
         m_exp = {m_hit && !m_und, m_hit && !m_und, m_tick, m_zero, m_run, m_nodata, m_irq};
         m_eff = (clk_div_in < 2) ? 2 : int'(clk_div_in);
         m_tick = m_hit;
         m_zero = m_und;
         if (m_hit) m_next = cyc + m_eff;
         if (m_und) m_nodata = 1;
         else if (clr_in && !m_run) m_nodata = 0;
         if (m_und && IRQ_EN) m_irq = 1;
         else if (irqack_in || (clr_in && !m_run)) m_irq = 0;
         if (stop_in) m_run = 0;
         else if (start_in && !m_run) begin
            m_run = 1;
            m_next = cyc + m_eff;
         end
      end
      n_cmp++;
      if (m_act !== m_exp) begin
         n_fail++;
         $display("FAIL model cyc=%0d got=%b want=%b (pop_l pop_r tick zero play nodata irq)",
                  cyc, m_act, m_exp);
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      start_in = 0; stop_in = 0; clr_in = 0; irqack_in = 0;
   endtask

   task automatic do_reset();
      nxt();
      rst_n = 0; l_empty_in = 0; r_empty_in = 0;
      nxt();
      nxt();
      rst_n = 1;
   endtask

   task automatic scen(input int n, input int div0, input int chg_c, input int div1,
                       input int start_c, input int stop_c, input int clr_c,
                       input int ack_c, input int remp_c);
      for (int c = 0; c < n; c++) begin
         nxt();
         if (c == 0) begin
            base = cyc;
            for (int i = 0; i < 64; i++) begin
               pop_log[i] = 0; tick_log[i] = 0; zero_log[i] = 0;
               play_log[i] = 0; nodata_log[i] = 0; irq_log[i] = 0;
            end
         end
         clk_div_in = (chg_c >= 0 && c >= chg_c) ? div1 : div0;
         start_in   = (c == start_c);
         stop_in    = (c == stop_c);
         clr_in     = (c == clr_c);
         irqack_in  = (c == ack_c);
         l_empty_in = 0;
         r_empty_in = (c == remp_c);
      end
      nxt();
   endtask

   typedef struct {
      int div;
      int first;
      int second;
   } per_t;
   per_t tbl [6];

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      tbl[0] = '{4, 4, 8};
      tbl[1] = '{1, 2, 4};
      tbl[2] = '{0, 2, 4};
      tbl[3] = '{2, 2, 4};
      tbl[4] = '{7, 7, 14};
      tbl[5] = '{3, 3, 6};

      #2;
      chk("reset_outputs", {1'b0, l_pop_out, r_pop_out, tick_out, zero_out, play_out, nodata_out, irq_out}, 8'h00);

      // Basic pacing at divide-by-4.
      do_reset();
      scen(16, 4, -1, 4, 0, -1, -1, -1, -1);
      chk("play_c0", play_log[0], 0);
      chk("play_c1", play_log[1], 1);
      for (int k = 4; k <= 12; k += 4) begin
         chk($sformatf("pop_c%0d", k), pop_log[k], 2'b11);
         chk($sformatf("nopop_c%0d", k - 1), pop_log[k - 1], 2'b00);
         chk($sformatf("tick_c%0d", k + 1), tick_log[k + 1], 1);
         chk($sformatf("zero_c%0d", k + 1), zero_log[k + 1], 0);
      end

      // Underrun, acknowledge, clear only after stop.
      do_reset();
      scen(22, 4, -1, 4, 0, 16, 18, 10, 8);
      chk("und_pop8", pop_log[8], 2'b00);
      chk("und_tick9", tick_log[9], 1);
      chk("und_zero9", zero_log[9], 1);
      chk("und_nodata8", nodata_log[8], 0);
      chk("und_nodata9", nodata_log[9], 1);
      chk("und_irq9", irq_log[9], IRQ_EN);
      chk("und_irq11", irq_log[11], 0);
      chk("und_nodata11", nodata_log[11], 1);
      chk("und_pop12", pop_log[12], 2'b11);
      chk("und_zero13", zero_log[13], 0);
      chk("und_nodata17", nodata_log[17], 1);
      chk("und_nodata19", nodata_log[19], 0);

      // Stop in the pop cycle.
      do_reset();
      scen(16, 4, -1, 4, 0, 8, -1, -1, -1);
      chk("stop_pop8", pop_log[8], 2'b11);
      chk("stop_play8", play_log[8], 1);
      chk("stop_tick9", tick_log[9], 1);
      chk("stop_play9", play_log[9], 0);
      chk("stop_pop12", pop_log[12], 2'b00);
      chk("stop_tick13", tick_log[13], 0);

      // Start and stop together while stopped.
      do_reset();
      scen(22, 4, -1, 4, 0, 0, -1, -1, -1);
      cnt = 0;
      for (int k = 1; k < 22; k++) cnt += int'(pop_log[k] != 0) + int'(tick_log[k]) + int'(play_log[k]);
      chk("startstop_quiet", 8'(cnt), 8'h00);

      // Divider period table, including the minimum clamp.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         scen(tbl[i].second + 3, tbl[i].div, -1, tbl[i].div, 0, -1, -1, -1, -1);
         chk($sformatf("per%0d_first", tbl[i].div), pop_log[tbl[i].first], 2'b11);
         chk($sformatf("per%0d_early", tbl[i].div), pop_log[tbl[i].first - 1], 2'b00);
         chk($sformatf("per%0d_second", tbl[i].div), pop_log[tbl[i].second], 2'b11);
         chk($sformatf("per%0d_tick", tbl[i].div), tick_log[tbl[i].first + 1], 1);
      end

      // Divider change takes effect at the next reload.
      do_reset();
      scen(24, 4, 5, 6, 0, -1, -1, -1, -1);
      chk("chg_pop8", pop_log[8], 2'b11);
      chk("chg_pop12", pop_log[12], 2'b00);
      chk("chg_pop13", pop_log[13], 2'b00);
      chk("chg_pop14", pop_log[14], 2'b11);
      chk("chg_pop20", pop_log[20], 2'b11);

      // Asynchronous reset mid-period, then with a tick pending.
      do_reset();
      scen(3, 4, -1, 4, 0, -1, -1, -1, -1);
      chk("rst_mid_play", play_out, 1);
      #2 rst_n = 0;
      #1 chk("rst_mid_outs", {1'b0, l_pop_out, r_pop_out, tick_out, zero_out, play_out, nodata_out, irq_out}, 8'h00);
      nxt();
      rst_n = 1;
      scen(5, 4, -1, 4, 0, -1, -1, -1, -1);
      chk("rst_tick_pending", tick_out, 1);
      #2 rst_n = 0;
      #1 chk("rst_tick_outs", {1'b0, l_pop_out, r_pop_out, tick_out, zero_out, play_out, nodata_out, irq_out}, 8'h00);
      nxt();
      nxt();
      rst_n = 1;
      scen(20, 4, -1, 4, -1, -1, -1, -1, -1);
      cnt = 0;
      for (int k = 0; k < 20; k++) cnt += int'(pop_log[k] != 0) + int'(tick_log[k]) + int'(play_log[k]);
      chk("rst_no_tick_after", 8'(cnt), 8'h00);

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         nxt();
         clk_div_in = $urandom_range(0, 6);
         start_in   = ($urandom_range(0, 19) == 0);
         stop_in    = ($urandom_range(0, 39) == 0);
         clr_in     = ($urandom_range(0, 14) == 0);
         irqack_in  = ($urandom_range(0, 9) == 0);
         l_empty_in = ($urandom_range(0, 7) == 0);
         r_empty_in = ($urandom_range(0, 7) == 0);
         if (!rst_n) rst_n = 1;
         else if ($urandom_range(0, 499) == 0) rst_n = 0;
      end
      nxt();
      rst_n = 1;
      nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter DIV_W, default 32, is the width of the clock-divider input.
REQ-002 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port start_in, input, 1: one-cycle CMD_START pulse.
REQ-005 Port stop_in, input, 1: one-cycle CMD_STOP pulse.
REQ-006 Port clr_in, input, 1: one-cycle CMD_CLR pulse.
REQ-007 Port irqack_in, input, 1: one-cycle CMD_IRQACK pulse.
REQ-008 Port clk_div_in, input, DIV_W: number of clk cycles per stereo sample.
REQ-009 Ports l_empty_in and r_empty_in, input, 1 each: left and right audio FIFO empty flags.
REQ-010 Ports l_pop_out and r_pop_out, output, 1 each: FIFO read strobes.
REQ-011 Port tick_out, output, 1: sample strobe to dsp_unit.
REQ-012 Port zero_out, output, 1: qualifies tick_out; the sample shall be treated as zero (underrun).
REQ-013 Ports play_out and nodata_out, output, 1 each: STATUS_PLAY and STATUS_NODATA bits.
REQ-014 Port irq_out, output, 1: level interrupt request.

Function
REQ-015 FSM states: STOPPED, COUNT; a separate tick_pending flop holds the tick owed for a pop or underrun.
REQ-016 STOPPED -> COUNT on start_in with stop_in low; the divider loads eff_div-1.
REQ-017 eff_div = max(clk_div_in, 2); clk_div_in is sampled at start and at every reload.
REQ-018 In COUNT the divider decrements each cycle; at 0 it reloads eff_div-1, giving an exact eff_div-cycle period.
REQ-019 Divider = 0 with both empty flags low: l_pop_out = r_pop_out = 1 in that same cycle (combinational from state/counter).
REQ-020 Divider = 0 with either empty flag high: no pop on either side; zero_out is set for the coming tick; nodata_out is set (sticky).
REQ-021 tick_out pulses exactly one cycle after each divider-zero cycle, with zero_out valid in the same cycle.
REQ-022 Left and right pops are always simultaneous; a single-sided pop is forbidden.
REQ-023 stop_in: COUNT -> STOPPED next edge, divider frozen; a tick already pending is still emitted, and no further pops occur.
REQ-024 start_in and stop_in in the same cycle: stop wins.
REQ-025 start_in while in COUNT: ignored.
REQ-026 play_out = 1 exactly while the state is COUNT (registered).
REQ-027 clr_in clears nodata_out and irq_out only when in STOPPED; it is ignored in COUNT.
REQ-028 irq_out is set on every underrun (REQ-020) and cleared by irqack_in; set wins when both occur in the same cycle.

Reset
REQ-029 rst_n low asynchronously forces: STOPPED, divider 0, tick_pending 0, and all outputs 0.
REQ-030 Reset mid-play drops any pending tick; there is no tick after release until a new start_in.

Configuration
REQ-031 With SAMPLE_SCHEDULER_IRQ_EN defined: irq_out behaves per REQ-028.
REQ-032 Without SAMPLE_SCHEDULER_IRQ_EN: irq_out is tied to 0, irqack_in is unused, and there is no irq flop; nodata_out is unchanged.

Structure
REQ-033 audioport_pkg shall hold typedef enum sched_state_t {STOPPED, COUNT} and localparam int SCHED_MIN_DIV = 2.
REQ-034 The divider shall be a sub-module sched_divider (load, enable, DIV_W down-counter, zero flag); the FSM, flags and IRQ logic stay in sample_scheduler.

Verification
REQ-035 clk_div_in = 4, FIFOs non-empty, start at cycle 0 -> pops at cycles 4, 8, 12; ticks at 5, 9, 13; zero_out = 0; play_out = 1 from cycle 1.
REQ-036 r_empty_in = 1 at cycle 8 -> no pops; tick at 9 with zero_out = 1; nodata_out = irq_out = 1 from 9; irqack_in -> irq_out = 0 while nodata_out stays 1; stop then clr -> nodata_out = 0.
REQ-037 stop_in in the pop cycle 8 -> tick still at 9, play_out = 0 at 9, no pop at 12.
REQ-038 start_in and stop_in together in STOPPED -> play_out stays 0; no pop or tick for 20 cycles.
REQ-039 clk_div_in = 1 and 0 -> pop period of 2 cycles; clk_div_in changed 4->6 mid-play -> the next period after the reload is 6.
REQ-040 rst_n low mid-period and with a tick pending -> all outputs 0 immediately (asynchronously); no tick after release.
